// File: rtl/sc_down_speed_counter.sv
// sc_down_speed_counter: loadable, saturating down counter with a terminal
// count pulse. Load has priority over decrement; decrement is honoured only
// while the count is nonzero, so the count never wraps.
// Optional feature: define SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN to turn the block
// into a periodic timer that reloads the last loaded value on terminal count.
module sc_down_speed_counter #(
  parameter int DOWNSPEEDCOUNTER_DATAWIDTH = 8
) (
  input  logic                                  SC_downSPEEDCOUNTER_CLOCK_50,
  input  logic                                  SC_downSPEEDCOUNTER_RESET_InHigh,
  input  logic                                  SC_downSPEEDCOUNTER_load_InLow,
  input  logic [DOWNSPEEDCOUNTER_DATAWIDTH-1:0] SC_downSPEEDCOUNTER_data_InBUS,
  input  logic                                  SC_downSPEEDCOUNTER_downcount_InLow,
  output logic [DOWNSPEEDCOUNTER_DATAWIDTH-1:0] SC_downSPEEDCOUNTER_data_OutBUS,
  output logic                                  SC_downSPEEDCOUNTER_zero_OutHigh,
  output logic                                  SC_downSPEEDCOUNTER_busy_OutHigh,
  output logic                                  SC_downSPEEDCOUNTER_done_OutHigh
);

  localparam int W = DOWNSPEEDCOUNTER_DATAWIDTH;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  // Next-state, next-count and done pulse: load > decrement > hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (!SC_downSPEEDCOUNTER_load_InLow) begin
      count_d = SC_downSPEEDCOUNTER_data_InBUS;
      state_d = (SC_downSPEEDCOUNTER_data_InBUS != '0) ? COUNT : IDLE;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
      reload_d = SC_downSPEEDCOUNTER_data_InBUS;
`endif
    end else if (!SC_downSPEEDCOUNTER_downcount_InLow && (state_q == COUNT)) begin
      if (count_q == CNT_ONE) begin
        // Terminal count: done rises together with the wrap-back value.
        done_d = 1'b1;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
        // COUNT is only entered through a nonzero load, so reload_q is nonzero here.
        count_d = reload_q;
        state_d = COUNT;
`else
        count_d = '0;
        state_d = IDLE;
`endif
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // State, count and done registers with synchronous reset.
  always_ff @(posedge SC_downSPEEDCOUNTER_CLOCK_50) begin
    if (SC_downSPEEDCOUNTER_RESET_InHigh) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef SC_DOWNSPEEDCOUNTER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign SC_downSPEEDCOUNTER_data_OutBUS  = count_q;
  assign SC_downSPEEDCOUNTER_zero_OutHigh = (count_q == '0);
  assign SC_downSPEEDCOUNTER_busy_OutHigh = (state_q == COUNT);
  assign SC_downSPEEDCOUNTER_done_OutHigh = done_q;

endmodule
